run_ctrl: RTL and testbench

Run sequencer that sits directly upstream of the processor top level and drives its `start` input while consuming its `halt` output. A host pulses `go`. The block then asserts `start` for a programmable number of cycles, releases the core, and counts executed cycles until `halt` rises or a watchdog expires. It reports completion through a `done`/`ack` handshake and keeps the core out of reset afterwards, so data memory stays readable.

---
 rtl/run_ctrl.sv | 157 +++++++++++++++
 tb/tb_run_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run sequencer: pulses the core's start, counts RUN cycles until halt or watchdog, then holds done until ack/go.
// Latency: every output is registered; input to output is one CLK edge, START lasts START_CYCLES cycles.
// Backpressure: done is held until the host answers with ack or go; go and ack are ignored in START and RUN.
//
// Ports:
//   CLK, reset_n       - clock, asynchronous active-low reset
//   go, ack            - host run request / completion acknowledge
//   halt               - done flag from the core
//   start              - init to the core, active high
//   busy, done         - status: START/RUN, DONE
//   timeout            - last run ended by watchdog (meaningful while done)
//   cycle_ct           - RUN cycles with halt=0 in the last or current run
//
// Build option: define RUN_CTRL_WDOG_EN to build the watchdog. Without it,
// timeout is constant 0, RUN ends only on halt, and TIMEOUT is unused.
module run_ctrl #(
    parameter int unsigned        START_CYCLES = 2,
    parameter int unsigned        CW           = 16,
    parameter logic [CW-1:0]      TIMEOUT      = 16'hFFF0
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          go,
    input  logic          ack,
    input  logic          halt,
    output logic          start,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_ct
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cycle_ct_q, cycle_ct_d;
    logic [3:0]    pulse_ct_q, pulse_ct_d;

    localparam logic [3:0] PULSE_LAST = 4'(START_CYCLES);

`ifdef RUN_CTRL_WDOG_EN
    localparam logic [CW-1:0] WDOG_LAST = TIMEOUT - 1'b1;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT;
`endif

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            cycle_ct_q <= '0;
            pulse_ct_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            cycle_ct_q <= cycle_ct_d;
            pulse_ct_q <= pulse_ct_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        busy_d     = busy_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        cycle_ct_d = cycle_ct_q;
        pulse_ct_d = pulse_ct_q;

        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d    = ST_START;
                    start_d    = 1'b1;
                    busy_d     = 1'b1;
                    cycle_ct_d = '0;
                    timeout_d  = 1'b0;
                    pulse_ct_d = 4'd1;
                end
            end
            ST_START: begin
                // pulse_ct counts the START cycles already spent, including this one;
                // halt is deliberately not looked at here since it may be stale.
                if (pulse_ct_q == PULSE_LAST) begin
                    state_d    = ST_RUN;
                    start_d    = 1'b0;
                    pulse_ct_d = '0;
                end else begin
                    pulse_ct_d = pulse_ct_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    // halt beats a simultaneous watchdog expiry
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef RUN_CTRL_WDOG_EN
                end else if (cycle_ct_q == WDOG_LAST) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                    cycle_ct_d = TIMEOUT;
`endif
                end else if (cycle_ct_q != {CW{1'b1}}) begin
                    cycle_ct_d = cycle_ct_q + 1'b1;
                end
            end
            ST_DONE: begin
                // start stays low so the core keeps its data memory readable
                if (go) begin
                    state_d    = ST_START;
                    start_d    = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    cycle_ct_d = '0;
                    timeout_d  = 1'b0;
                    pulse_ct_d = 4'd1;
                end else if (ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign start    = start_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef RUN_CTRL_WDOG_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif
    assign cycle_ct = cycle_ct_q;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

    logic        CLK;
    logic        reset_n;
    logic        go;
    logic        ack;
    logic        halt;
    logic        start;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_ct;

    int n_cmp;
    int n_bad;

    run_ctrl #(
        .START_CYCLES (2),
        .CW           (16),
        .TIMEOUT      (16'd20)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .go       (go),
        .ack      (ack),
        .halt     (halt),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .cycle_ct (cycle_ct)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        go;
        logic        ack;
        logic        halt;
        logic        e_start;
        logic        e_busy;
        logic        e_done;
        logic        e_to;
        logic [15:0] e_ct;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // advance one clock; outputs are then sampled on the falling edge
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk_all(input string name, input logic s, input logic b, input logic d,
                           input logic t, input logic [15:0] ct);
        chk({name, ".start"},    {31'd0, start},   {31'd0, s});
        chk({name, ".busy"},     {31'd0, busy},    {31'd0, b});
        chk({name, ".done"},     {31'd0, done},    {31'd0, d});
        chk({name, ".timeout"},  {31'd0, timeout}, {31'd0, t});
        chk({name, ".cycle_ct"}, {16'd0, cycle_ct}, {16'd0, ct});
    endtask

    // pulse go, then follow the start pulse to its end; returns at the first RUN cycle
    task automatic run_go(input string name);
        int n;
        go = 1'b1;
        step();
        go = 1'b0;
        n  = 0;
        while (start === 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk({name, ".start_width"}, n, 2);
        chk({name, ".in_run"}, {31'd0, busy}, 1);
    endtask

    initial begin
        int n;
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        go      = 1'b0;
        ack     = 1'b0;
        halt    = 1'b0;

        //                go ack hlt  st bz dn to  ct
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

        // reset state
        repeat (2) @(negedge CLK);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        reset_n = 1'b1;

        // table: one clock per record, inputs set on the falling edge
        for (int i = 0; i < NVEC; i++) begin
            go   = tbl[i].go;
            ack  = tbl[i].ack;
            halt = tbl[i].halt;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_start, tbl[i].e_busy,
                    tbl[i].e_done, tbl[i].e_to, tbl[i].e_ct);
        end
        go = 1'b0; ack = 1'b0; halt = 1'b0;

        // basic run: core halts 10 cycles after start falls
        run_go("basic");
        repeat (10) step();
        chk("basic.not_done", {31'd0, done}, 0);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_all("basic.done", 1'b0, 1'b0, 1'b1, 1'b0, 16'd10);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_all("basic.ack", 1'b0, 1'b0, 1'b0, 1'b0, 16'd10);

        // stale halt held through START, dropped on the first RUN cycle
        halt = 1'b1;
        go   = 1'b1;
        step();
        go = 1'b0;
        n  = 0;
        while (start === 1'b1 && n < 20) begin
            chk("stale.no_done", {31'd0, done}, 0);
            n++;
            step();
        end
        chk("stale.start_width", n, 2);
        halt = 1'b0;
        chk("stale.busy", {31'd0, busy}, 1);
        repeat (5) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_all("stale.done", 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // watchdog with halt never raised
        run_go("wdog");
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            n++;
            step();
        end
`ifdef RUN_CTRL_WDOG_EN
        chk("wdog.cycles", n, 20);
        chk_all("wdog.done", 1'b0, 1'b0, 1'b1, 1'b1, 16'd20);
`else
        chk("wdog.cycles", n, 40);
        chk_all("wdog.still_run", 1'b0, 1'b1, 1'b0, 1'b0, 16'd40);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_all("wdog.halt", 1'b0, 1'b0, 1'b1, 1'b0, 16'd40);
`endif
        ack = 1'b1;
        step();
        ack = 1'b0;

        // watchdog tie: halt arrives while cycle_ct = TIMEOUT-1
        run_go("tie");
        repeat (19) step();
        chk("tie.ct19", {16'd0, cycle_ct}, 19);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_all("tie.done", 1'b0, 1'b0, 1'b1, 1'b0, 16'd19);

        // go and ack together in DONE: go wins
        go  = 1'b1;
        ack = 1'b1;
        step();
        go  = 1'b0;
        ack = 1'b0;
        chk_all("hs.go_wins", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
        step();
        step();
        repeat (4) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_all("hs.done", 1'b0, 1'b0, 1'b1, 1'b0, 16'd4);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_all("hs.ack_only", 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);

        // asynchronous reset between edges in RUN
        run_go("arst");
        repeat (3) step();
        @(posedge CLK);
        #2 reset_n = 1'b0;
        #1 chk_all("arst.immediate", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        step();
        chk_all("arst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        go = 1'b1;
        step();
        go = 1'b0;
        chk_all("arst.restart", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
